// File: rtl/jh_io_pkg.sv
// Shared constants and state encoding for the JH host I/O controller.
package jh_io_pkg;

  localparam int unsigned IOSIZE           = 16;
  localparam int unsigned BLOCK_W          = 512;
  localparam int unsigned DIGEST_W         = 256;
  localparam int unsigned WORDS_PER_BLOCK  = BLOCK_W / IOSIZE;
  localparam int unsigned WORDS_PER_DIGEST = DIGEST_W / IOSIZE;
  localparam int unsigned WCNT_W           = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned DCNT_W           = $clog2(WORDS_PER_DIGEST);
  localparam int unsigned IOSIZE_SH        = $clog2(IOSIZE);

  typedef enum logic [1:0] {IDLE, FILL, HASH, OUT} state_t;

endpackage

// File: rtl/jh_io_ctrl_if.sv
// Host-side init/load/fetch/ack word protocol bundle.
interface jh_io_ctrl_if;
  import jh_io_pkg::*;

  logic              init;
  logic              load;
  logic              fetch;
  logic [IOSIZE-1:0] idata;
  logic              ack;
  logic [IOSIZE-1:0] odata;
  logic              err;

  modport master (output init, load, fetch, idata, input ack, odata, err);
  modport slave  (input init, load, fetch, idata, output ack, odata, err);

endinterface

// File: rtl/jh_io_ctrl.sv
// JH host I/O controller: packs 32 host words into a 512-bit block for the
// compression core and drains the 256-bit digest as 16 host words.
module jh_io_ctrl
  import jh_io_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  jh_io_ctrl_if.slave         host,
  output logic                core_init,
  output logic                core_start,
  output logic [BLOCK_W-1:0]  core_block,
  input  logic                core_busy,
  input  logic [DIGEST_W-1:0] core_digest
);

  state_t              r_state;
  logic [WCNT_W-1:0]   r_wcnt;
  logic [DCNT_W-1:0]   r_dcnt;
  logic [BLOCK_W-1:0]  r_block;
  logic [DIGEST_W-1:0] r_digest;
  logic                r_ack;
  logic [IOSIZE-1:0]   r_odata;
  logic                r_err;
  logic                r_core_init;
  logic                r_core_start;

  // Word 0 sits in the top bits, so the slice index counts down as dcnt rises.
  logic [DCNT_W-1:0]   w_dsel;
  logic [IOSIZE-1:0]   w_dword;

  // Select the digest word addressed by dcnt from the captured digest.
  always_comb begin
    w_dsel  = ~r_dcnt;
    w_dword = r_digest[{w_dsel, {IOSIZE_SH{1'b0}}} +: IOSIZE];
  end

  // Protocol FSM: block assembly, core handoff and digest drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_wcnt       <= '0;
      r_dcnt       <= '0;
      r_block      <= '0;
      r_digest     <= '0;
      r_ack        <= 1'b0;
      r_odata      <= '0;
      r_err        <= 1'b0;
      r_core_init  <= 1'b0;
      r_core_start <= 1'b0;
    end else begin
      r_ack        <= 1'b0;
      r_core_init  <= 1'b0;
      r_core_start <= 1'b0;
      if (host.init) begin
        r_core_init <= 1'b1;
        r_wcnt      <= '0;
        r_dcnt      <= '0;
        r_err       <= 1'b0;
        r_state     <= FILL;
      end else begin
        if (host.load && host.fetch && (r_state != HASH)) begin
          r_err <= 1'b1;
        end
        unique case (r_state)
          IDLE: begin
          end
          FILL: begin
            if (host.load) begin
              if (!r_ack) begin
                r_block <= {r_block[BLOCK_W-IOSIZE-1:0], host.idata};
                r_wcnt  <= r_wcnt + 1'b1;
                r_ack   <= 1'b1;
                if (r_wcnt == WCNT_W'(WORDS_PER_BLOCK - 1)) begin
                  r_core_start <= 1'b1;
                  r_state      <= HASH;
                end
              end
            end else if (host.fetch) begin
              if (r_wcnt != '0) begin
                r_err <= 1'b1;
              end else if (!r_ack) begin
                r_digest <= core_digest;
                r_odata  <= core_digest[DIGEST_W-1 -: IOSIZE];
                r_dcnt   <= DCNT_W'(1);
                r_ack    <= 1'b1;
                r_state  <= OUT;
              end
            end
          end
          HASH: begin
            // core_busy is not yet valid in the core_start cycle itself.
            if (!r_core_start && !core_busy) begin
              r_state <= FILL;
            end
          end
          OUT: begin
            if (host.fetch) begin
              if (!r_ack) begin
                r_odata <= w_dword;
                r_ack   <= 1'b1;
                r_dcnt  <= r_dcnt + 1'b1;
                if (r_dcnt == DCNT_W'(WORDS_PER_DIGEST - 1)) begin
                  r_state <= IDLE;
                end
              end
            end else if (host.load) begin
              r_err <= 1'b1;
            end
          end
        endcase
      end
    end
  end

  assign host.ack   = r_ack;
  assign host.odata = r_odata;
  assign host.err   = r_err;
  assign core_init  = r_core_init;
  assign core_start = r_core_start;
  assign core_block = r_block;

endmodule

// File: tb/tb_jh_io_ctrl.sv
// Directed bench for jh_io_ctrl with a fixed-latency core stub.
module tb_jh_io_ctrl;
  import jh_io_pkg::*;

  logic                clk;
  logic                rst;
  logic                core_init;
  logic                core_start;
  logic [BLOCK_W-1:0]  core_block;
  logic                core_busy;
  logic [DIGEST_W-1:0] core_digest;

  int checks;
  int errors;

  int busy_cnt;
  int start_cnt;
  int init_cnt;
  logic [BLOCK_W-1:0] last_block;

  jh_io_ctrl_if bus ();

  jh_io_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .host        (bus),
    .core_init   (core_init),
    .core_start  (core_start),
    .core_block  (core_block),
    .core_busy   (core_busy),
    .core_digest (core_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign core_digest = 256'h0001_0002_0003_0004_0005_0006_0007_0008_0009_000A_000B_000C_000D_000E_000F_0010;
  assign core_busy   = (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) busy_cnt <= 0;
    else if (core_start) busy_cnt <= 42;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end

  always @(posedge clk) begin
    if (core_start) begin
      start_cnt  = start_cnt + 1;
      last_block = core_block;
    end
    if (core_init) init_cnt = init_cnt + 1;
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_init();
    bus.init = 1'b1;
    @(posedge clk); #1;
    bus.init = 1'b0;
  endtask

  task automatic load_words(input logic [15:0] base, input int n, input bit keep,
                            input logic [15:0] tail, output int acks, output bit start_last);
    acks = 0;
    start_last = 1'b0;
    bus.load = 1'b1;
    bus.idata = base;
    for (int c = 0; c < n * 2 + 20 && acks < n; c++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        acks++;
        if (acks == n) begin
          start_last = core_start;
          if (keep) bus.idata = tail;
          else bus.load = 1'b0;
        end else begin
          bus.idata = base + 16'(acks);
        end
      end
    end
    if (!keep) bus.load = 1'b0;
  endtask

  task automatic fetch_words(input int n, output logic [15:0] w [16], output int got, output int dbl);
    bit prev;
    got = 0;
    dbl = 0;
    prev = 1'b0;
    for (int i = 0; i < 16; i++) w[i] = '0;
    bus.fetch = 1'b1;
    for (int c = 0; c < n * 2 + 60 && got < n; c++) begin
      @(posedge clk); #1;
      if (bus.ack) begin
        if (prev) dbl++;
        w[got] = bus.odata;
        got++;
      end
      prev = bus.ack;
    end
    bus.fetch = 1'b0;
  endtask

  task automatic wait_core_done(output bit ok);
    bit seen;
    ok = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(posedge clk); #1;
      if (core_busy) seen = 1'b1;
      else if (seen) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    int acks;
    rst = 1'b1;
    cyc(2);
    checks++;
    if (bus.ack !== 1'b0 || bus.odata !== 16'h0 || bus.err !== 1'b0 || core_init !== 1'b0 ||
        core_start !== 1'b0 || core_block !== '0) begin
      errors++;
      $display("FAIL reset_values: ack=%b odata=%h err=%b init=%b start=%b blk_nz=%b required all 0",
               bus.ack, bus.odata, bus.err, core_init, core_start, core_block != '0);
    end
    rst = 1'b0;
    acks = 0;
    bus.load = 1'b1;
    bus.idata = 16'h1234;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.ack) acks++;
    end
    bus.load = 1'b0;
    checks++;
    if (acks !== 0) begin
      errors++;
      $display("FAIL load_no_init_ack: acks=%0d required 0", acks);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL load_no_init_err: err=%b required 0", bus.err);
    end
  endtask

  task automatic test_one_block();
    int acks, got, dbl, s0, late;
    bit sl, ok;
    logic [15:0] w [16];
    s0 = start_cnt;
    pulse_init();
    checks++;
    if (core_init !== 1'b1) begin
      errors++;
      $display("FAIL init_pulse: core_init=%b required 1", core_init);
    end
    load_words(16'h0000, 32, 1'b0, 16'h0, acks, sl);
    checks++;
    if (acks !== 32 || sl !== 1'b1) begin
      errors++;
      $display("FAIL block_load: acks=%0d start_with_ack=%b required 32/1", acks, sl);
    end
    wait_core_done(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL core_wait: timeout waiting for busy to fall");
    end
    checks++;
    if (start_cnt - s0 !== 1 || last_block[511:496] !== 16'h0000 || last_block[15:0] !== 16'h001F ||
        last_block[271:256] !== 16'h000F) begin
      errors++;
      $display("FAIL block_start: starts=%0d top=%h bot=%h w15=%h required 1/0000/001f/000f",
               start_cnt - s0, last_block[511:496], last_block[15:0], last_block[271:256]);
    end
    fetch_words(16, w, got, dbl);
    checks++;
    if (got !== 16 || dbl !== 0) begin
      errors++;
      $display("FAIL drain_count: words=%0d double_acks=%0d required 16/0", got, dbl);
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (w[i] !== 16'(i + 1)) begin
        errors++;
        $display("FAIL digest_word%0d: odata=%h required %h", i, w[i], 16'(i + 1));
      end
    end
    bus.fetch = 1'b1;
    late = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack) late++;
    end
    bus.fetch = 1'b0;
    checks++;
    if (late !== 0 || start_cnt - s0 !== 1 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL after_drain: acks=%0d starts=%0d err=%b required 0/1/0", late, start_cnt - s0, bus.err);
    end
  endtask

  task automatic test_back_to_back();
    int acks, wait_c, early;
    bit sl, got;
    pulse_init();
    load_words(16'h0100, 32, 1'b1, 16'hABCD, acks, sl);
    checks++;
    if (acks !== 32 || sl !== 1'b1) begin
      errors++;
      $display("FAIL bp_load: acks=%0d start=%b required 32/1", acks, sl);
    end
    got = 1'b0;
    wait_c = 0;
    early = 0;
    for (int c = 0; c < 120 && !got; c++) begin
      @(posedge clk); #1;
      wait_c++;
      if (c == 5) begin
        checks++;
        if (core_block[15:0] !== 16'h011F) begin
          errors++;
          $display("FAIL bp_block_hold: blk_lsw=%h required 011f", core_block[15:0]);
        end
      end
      if (bus.ack) begin
        got = 1'b1;
        if (wait_c < 45) early++;
      end
    end
    bus.load = 1'b0;
    checks++;
    if (!got || wait_c !== 45 || early !== 0) begin
      errors++;
      $display("FAIL bp_ack_delay: got=%b cycles=%0d required 1/45", got, wait_c);
    end
    checks++;
    if (dut.r_wcnt !== 5'd1 || core_block[15:0] !== 16'hABCD) begin
      errors++;
      $display("FAIL bp_wcnt: wcnt=%0d blk_lsw=%h required 1/abcd", dut.r_wcnt, core_block[15:0]);
    end
  endtask

  task automatic test_partial_fetch();
    int acks, fa;
    bit sl;
    pulse_init();
    load_words(16'h0300, 5, 1'b0, 16'h0, acks, sl);
    bus.fetch = 1'b1;
    fa = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack) fa++;
    end
    bus.fetch = 1'b0;
    checks++;
    if (acks !== 5 || fa !== 0 || bus.err !== 1'b1) begin
      errors++;
      $display("FAIL partial_fetch: loads=%0d fetch_acks=%0d err=%b required 5/0/1", acks, fa, bus.err);
    end
    pulse_init();
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL init_clears_err: err=%b required 0", bus.err);
    end
  endtask

  task automatic test_conflict_reset();
    int acks, got, dbl, fa;
    bit sl, ok;
    logic [15:0] w [16];
    bus.load = 1'b1;
    bus.fetch = 1'b1;
    bus.idata = 16'h5555;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      @(posedge clk); #1;
      if (bus.ack) got = 1;
    end
    bus.load = 1'b0;
    bus.fetch = 1'b0;
    checks++;
    if (got !== 1 || bus.err !== 1'b1 || core_block[15:0] !== 16'h5555) begin
      errors++;
      $display("FAIL conflict_fill: ack=%0d err=%b blk_lsw=%h required 1/1/5555", got, bus.err, core_block[15:0]);
    end
    pulse_init();
    load_words(16'h0400, 32, 1'b0, 16'h0, acks, sl);
    wait_core_done(ok);
    fetch_words(7, w, got, dbl);
    checks++;
    if (!ok || got !== 7 || w[6] !== 16'h0007 || bus.odata !== 16'h0007) begin
      errors++;
      $display("FAIL pre_reset_drain: ok=%b words=%0d w6=%h required 1/7/0007", ok, got, w[6]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (bus.ack !== 1'b0 || bus.odata !== 16'h0 || bus.err !== 1'b0 || dut.r_state !== IDLE) begin
      errors++;
      $display("FAIL mid_drain_reset: ack=%b odata=%h err=%b state=%0d required 0/0000/0/IDLE",
               bus.ack, bus.odata, bus.err, dut.r_state);
    end
    bus.fetch = 1'b1;
    fa = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (bus.ack) fa++;
    end
    bus.fetch = 1'b0;
    checks++;
    if (fa !== 0) begin
      errors++;
      $display("FAIL fetch_after_reset: acks=%0d required 0", fa);
    end
  endtask

  task automatic test_init_abort();
    int acks, s0, i0;
    bit sl;
    pulse_init();
    load_words(16'h0500, 32, 1'b0, 16'h0, acks, sl);
    cyc(3);
    s0 = start_cnt;
    i0 = init_cnt;
    checks++;
    if (core_busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_setup: busy=%b required 1", core_busy);
    end
    pulse_init();
    checks++;
    if (core_init !== 1'b1) begin
      errors++;
      $display("FAIL abort_init_pulse: core_init=%b required 1", core_init);
    end
    cyc(5);
    checks++;
    if (start_cnt !== s0 || init_cnt - i0 !== 1) begin
      errors++;
      $display("FAIL abort_no_start: starts=%0d inits=%0d required 0/1", start_cnt - s0, init_cnt - i0);
    end
    load_words(16'h0200, 32, 1'b0, 16'h0, acks, sl);
    cyc(1);
    checks++;
    if (acks !== 32 || sl !== 1'b1 || start_cnt - s0 !== 1 || last_block[511:496] !== 16'h0200 ||
        last_block[15:0] !== 16'h021F) begin
      errors++;
      $display("FAIL abort_fresh_block: acks=%0d starts=%0d top=%h bot=%h required 32/1/0200/021f",
               acks, start_cnt - s0, last_block[511:496], last_block[15:0]);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    start_cnt = 0;
    init_cnt = 0;
    last_block = '0;
    rst = 1'b1;
    bus.init = 1'b0;
    bus.load = 1'b0;
    bus.fetch = 1'b0;
    bus.idata = '0;
    @(posedge clk); #1;
    test_reset();
    test_one_block();
    test_back_to_back();
    test_partial_fetch();
    test_conflict_reset();
    test_init_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jh_io_ctrl.md
# jh_io_ctrl

Host-side I/O controller for the JH hash core. It terminates the 16-bit init/load/fetch/ack word protocol that the command-file bench drives. It assembles 32 loaded words into a 512-bit message block, hands each block to the JH compression core, and serialises the 256-bit digest back out as 16 fetched words. It sits between the chip pads and the core inside the JH top level; the host does all message padding.

## Interface
- IOSIZE, 16, host word width
- BLOCK_W, 512, message block width (32 words)
- DIGEST_W, 256, digest width (16 words)
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- init  in  1  host: start new message (one-cycle pulse)
- load  in  1  host: idata holds a message word
- fetch  in  1  host: request next digest word
- idata  in  IOSIZE  host write data
- ack  out  1  one-cycle acknowledge of an accepted load/fetch
- odata  out  IOSIZE  digest word, valid while ack=1, held afterwards
- err  out  1  sticky protocol error
- core_init  out  1  one-cycle pulse: clear chaining state to IV
- core_start  out  1  one-cycle pulse: core_block valid
- core_block  out  BLOCK_W  assembled block, first word in [511:496]
- core_busy  in  1  core compressing
- core_digest  in  DIGEST_W  final chaining value, stable while core_busy=0

## Operation
- States: IDLE, FILL, HASH, OUT.
- IDLE: entered on reset and after a full drain. load and fetch get no ack. init moves to FILL.
- init in any state: pulse core_init, clear word counter and err, go to FILL. init wins over load and fetch in the same cycle. init during HASH abandons the block; the core must accept core_init at any time.
- FILL, load=1 and ack=0 at a clk edge:
  - shift idata into the block register (MSB-first);
  - increment wcnt (5-bit);
  - assert ack for the next cycle.
- When wcnt wraps 31→0: pulse core_start with core_block the cycle after the 32nd ack, then go to HASH.
- HASH: load and fetch are not acked. Return to FILL on the first cycle with core_busy=0 after core_start.
- FILL, fetch=1, ack=0, wcnt=0: go to OUT. Sample core_digest, present word 0 (core_digest[255:240]) on odata, assert ack.
- FILL, fetch with wcnt≠0 (partial block): no ack, set err.
- OUT, fetch=1 and ack=0: present next digest word and ack. After word 15 is acked, go to IDLE.
- OUT, load=1: set err, no ack.
- load and fetch high together outside HASH: set err. load takes priority in FILL; fetch takes priority in OUT.
- Host holding load or fetch high continuously is legal. Throughput is one word per two cycles, because ack gates re-acceptance.

## Timing
- Reset values: ack=0, odata=0, err=0, core_init=0, core_start=0, core_block=0, wcnt=0, dcnt=0, state=IDLE.
- All outputs are registered.
- ack rises 1 cycle after the sampling edge and stays high for exactly 1 cycle.
- core_start follows the 32nd word's capture edge by 1 cycle (coincident with its ack).
- A block of 32 loads takes 64 cycles minimum, plus core latency.
- A digest drain takes 32 cycles minimum.
- rst mid-block or mid-drain: everything returns to reset values on the next edge and no core_start is issued. The core is not re-initialised until the host issues init.
- core_block is held stable from core_start until the next load capture.

## Structure
- Package jh_io_pkg holds:
  - IOSIZE, BLOCK_W, DIGEST_W;
  - derived WORDS_PER_BLOCK=32 and WORDS_PER_DIGEST=16 with their counter widths;
  - the state enum {IDLE, FILL, HASH, OUT}.
- Single module, no sub-module. The block shift register and the digest mux are inline; the digest is captured into a register on entry to OUT.

## Test plan
- Reset then load without init:
  - Stimulus: rst for 2 cycles, load with idata=0x1234 for 10 cycles.
  - Required: ack never rises; err=0.
- One-block message:
  - Stimulus: init, then 32 loads of 0x0000..0x001F with load held high. A core stub holds busy for 42 cycles and returns digest 0x0001_0002_…_0010.
  - Required: core_start exactly once, with core_block[511:496]=0x0000 and [15:0]=0x001F. 16 fetches return 0x0001..0x0010 in order, each with a single-cycle ack.
- Backpressure during HASH:
  - Stimulus: 33rd load issued immediately after the 32nd ack.
  - Required: no ack until core_busy falls, then ack; wcnt=1.
- Partial-block fetch:
  - Stimulus: init, 5 loads, fetch.
  - Required: no ack, err=1.
  - Stimulus: then init.
  - Required: err=0.
- Conflict and reset mid-operation:
  - Stimulus: load=fetch=1 in FILL.
  - Required: the word is accepted, err=1.
  - Stimulus: rst during OUT after 7 digest words.
  - Required: ack=0, odata=0, state IDLE; further fetch not acked.
- init abort:
  - Stimulus: init asserted while in HASH.
  - Required: core_init pulse, no further core_start; the next 32 loads produce a fresh core_start.
